// File: rtl/ahb_master_ctrl.sv
// AHB-Lite single-transfer master controller.
// Accepts one core request at a time, decodes it to the RAM or AI slave,
// runs one NONSEQ word transfer and returns a single-cycle response pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; bus idle
// ADDR    | address phase on the bus, waiting for HREADY
// DATA    | data phase, counting wait states against TIMEOUT
// RESP    | rsp_valid pulse, bus selects released
module ahb_master_ctrl #(
    parameter logic [31:0] AI_BASE = 32'h4000_0000,
    parameter logic [31:0] AI_MASK = 32'hF000_0000,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic        HSEL_RAM,
    output logic        HSEL_AI,
    input  logic [31:0] HRDATA_RAM,
    input  logic [31:0] HRDATA_AI,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    // The last wait cycle before giving up; TIMEOUT fits in 16 bits, so no wrap.
    localparam logic [15:0] WAIT_LAST     = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [31:0] r_hwdata;
    logic [31:0] r_wdata;
    logic        r_hsel_ram;
    logic        r_hsel_ai;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [15:0] r_wait;

    state_t      w_state;
    logic [31:0] w_haddr;
    logic [1:0]  w_htrans;
    logic        w_hwrite;
    logic [31:0] w_hwdata;
    logic [31:0] w_wdata;
    logic        w_hsel_ram;
    logic        w_hsel_ai;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err;
    logic [15:0] w_wait;
    logic        w_sel_ai;

    // State and all bus/response registers; reset drops any in-flight transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_haddr     <= '0;
            r_htrans    <= HTRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hwdata    <= '0;
            r_wdata     <= '0;
            r_hsel_ram  <= 1'b0;
            r_hsel_ai   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wait      <= '0;
        end else begin
            r_state     <= w_state;
            r_haddr     <= w_haddr;
            r_htrans    <= w_htrans;
            r_hwrite    <= w_hwrite;
            r_hwdata    <= w_hwdata;
            r_wdata     <= w_wdata;
            r_hsel_ram  <= w_hsel_ram;
            r_hsel_ai   <= w_hsel_ai;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_wait      <= w_wait;
        end
    end

    // Next-state and next-output decode; registers hold unless a transition updates them.
    always_comb begin
        w_state     = r_state;
        w_haddr     = r_haddr;
        w_htrans    = r_htrans;
        w_hwrite    = r_hwrite;
        w_hwdata    = r_hwdata;
        w_wdata     = r_wdata;
        w_hsel_ram  = r_hsel_ram;
        w_hsel_ai   = r_hsel_ai;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_wait      = r_wait;
        w_sel_ai    = ((req_addr & AI_MASK) == AI_BASE);

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_addr[1:0] != 2'b00) begin
                        // Misaligned word access never reaches the bus.
                        w_state     = ST_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = '0;
                    end else begin
                        w_state    = ST_ADDR;
                        w_haddr    = req_addr;
                        w_hwrite   = req_write;
                        w_wdata    = req_wdata;
                        w_htrans   = HTRANS_NONSEQ;
                        w_hsel_ai  = w_sel_ai;
                        w_hsel_ram = !w_sel_ai;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    w_state  = ST_DATA;
                    w_htrans = HTRANS_IDLE;
                    w_hwdata = r_wdata;
                    w_wait   = '0;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    w_state     = ST_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = HRESP;
                    w_rsp_rdata = r_hwrite  ? 32'h0 :
                                  r_hsel_ai ? HRDATA_AI : HRDATA_RAM;
                    w_hsel_ram  = 1'b0;
                    w_hsel_ai   = 1'b0;
                end else if (r_wait == WAIT_LAST) begin
                    w_state     = ST_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rsp_rdata = '0;
                    w_hsel_ram  = 1'b0;
                    w_hsel_ai   = 1'b0;
                end else begin
                    w_wait = r_wait + 16'd1;
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = 3'b010;
    assign HWDATA    = r_hwdata;
    assign HSEL_RAM  = r_hsel_ram;
    assign HSEL_AI   = r_hsel_ai;

endmodule
